// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the accumulator datapath.
// Drives register strobes, mux selects, ALU opcodes and memory requests.
module instr_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step_mode,
  input  logic [15:0]      ir_in,
  input  logic             acc_zero,
  input  logic             acc_neg,
  input  logic             mem_ready,
  output logic             mar_write,
  output logic             mar_sel,
  output logic             mbr_write,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             acc_write,
  output logic [1:0]       acc_sel,
  output logic [3:0]       alu_op,
  output logic             mem_req,
  output logic             mem_we,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             mem_fault,
  output logic [CNT_W-1:0] retired
);

  localparam int TW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;
  localparam logic [3:0] OP_SHL   = 4'hB;
  localparam logic [3:0] OP_SHR   = 4'hC;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FADDR,
    S_FMEM,
    S_FIR,
    S_DECODE,
    S_EADDR,
    S_EMEM,
    S_EALU,
    S_HALT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_tmo;
  logic [3:0]    w_op;
  logic          w_skip;
  logic          w_in_mem;
  logic          w_tmo_hit;
  logic          w_end;
  logic          w_ret;
  logic          w_ill;
  logic          w_flt;
  logic          w_unused;

  assign w_op     = ir_in[15:12];
  assign w_unused = ^ir_in[9:0];
  assign w_in_mem = (r_state == S_FMEM) || (r_state == S_EMEM);
  assign busy     = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted   = (r_state == S_HALT);

  // Timeout fires only while ready is still low at the limit
  assign w_tmo_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                     (r_tmo == TW'(MEM_TIMEOUT));

  // SKIPCOND condition select
  always_comb begin
    w_skip = 1'b0;
    case (ir_in[11:10])
      2'b00:   w_skip = acc_neg;
      2'b01:   w_skip = acc_zero;
      2'b10:   w_skip = !acc_neg && !acc_zero;
      default: w_skip = 1'b0;
    endcase
  end

  // Next state and per-state strobe decode
  always_comb begin
    w_next    = r_state;
    mar_write = 1'b0;
    mar_sel   = 1'b0;
    mbr_write = 1'b0;
    ir_write  = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    acc_write = 1'b0;
    acc_sel   = 2'd0;
    alu_op    = 4'b0000;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    w_end     = 1'b0;
    w_ret     = 1'b0;
    w_ill     = 1'b0;
    w_flt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FADDR;
      end
      S_FADDR: begin
        mar_write = 1'b1;
        w_next    = S_FMEM;
      end
      S_FMEM: begin
        if (mem_ready) begin
          mem_req   = 1'b1;
          mbr_write = 1'b1;
          pc_inc    = 1'b1;
          w_next    = S_FIR;
        end else if (w_tmo_hit) begin
          w_flt  = 1'b1;
          w_next = S_HALT;
        end else begin
          mem_req = 1'b1;
        end
      end
      S_FIR: begin
        ir_write = 1'b1;
        w_next   = S_DECODE;
      end
      S_DECODE: begin
        case (w_op)
          OP_LOAD, OP_STORE, OP_ADD,
          OP_SUBT, OP_AND, OP_OR: begin
            w_next = S_EADDR;
          end
          OP_JUMP: begin
            pc_load = 1'b1;
            w_end   = 1'b1;
          end
          OP_SKIP: begin
            pc_inc = w_skip;
            w_end  = 1'b1;
          end
          OP_CLEAR: begin
            acc_write = 1'b1;
            acc_sel   = 2'd2;
            w_end     = 1'b1;
          end
          OP_SHL: begin
            acc_write = 1'b1;
            alu_op    = 4'b0100;
            w_end     = 1'b1;
          end
          OP_SHR: begin
            acc_write = 1'b1;
            alu_op    = 4'b0101;
            w_end     = 1'b1;
          end
          OP_HALT: begin
            w_ret  = 1'b1;
            w_next = S_HALT;
          end
          default: begin
            w_ill  = 1'b1;
            w_next = S_HALT;
          end
        endcase
      end
      S_EADDR: begin
        mar_write = 1'b1;
        mar_sel   = 1'b1;
        w_next    = S_EMEM;
      end
      S_EMEM: begin
        if (mem_ready) begin
          mem_req = 1'b1;
          mem_we  = (w_op == OP_STORE);
          if (w_op == OP_STORE) begin
            w_end = 1'b1;
          end else begin
            mbr_write = 1'b1;
            w_next    = S_EALU;
          end
        end else if (w_tmo_hit) begin
          w_flt  = 1'b1;
          w_next = S_HALT;
        end else begin
          mem_req = 1'b1;
          mem_we  = (w_op == OP_STORE);
        end
      end
      S_EALU: begin
        acc_write = 1'b1;
        w_end     = 1'b1;
        case (w_op)
          OP_LOAD: acc_sel = 2'd1;
          OP_SUBT: alu_op  = 4'b0001;
          OP_AND:  alu_op  = 4'b1000;
          OP_OR:   alu_op  = 4'b1001;
          default: alu_op  = 4'b0000;
        endcase
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_end) begin
      w_ret  = 1'b1;
      w_next = step_mode ? S_IDLE : S_FADDR;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Sticky fault flags and retired-instruction counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      illegal   <= 1'b0;
      mem_fault <= 1'b0;
      retired   <= '0;
    end else begin
      if (w_ill) illegal <= 1'b1;
      if (w_flt) mem_fault <= 1'b1;
      if (w_ret) retired <= retired + 1'b1;
    end
  end

  // Consecutive not-ready cycles in the current memory state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo <= '0;
    end else if (w_in_mem && !mem_ready) begin
      if (r_tmo != '1) r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: per-opcode vector table,
// a small datapath model for a full program, and timing corner cases.
module tb_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run;
  logic        step_mode;
  logic [15:0] ir_in;
  logic        acc_zero;
  logic        acc_neg;
  logic        mem_ready;
  logic        mar_write, mar_sel, mbr_write, ir_write;
  logic        pc_inc, pc_load, acc_write;
  logic [1:0]  acc_sel;
  logic [3:0]  alu_op;
  logic        mem_req, mem_we, busy, halted;
  logic        illegal, mem_fault;
  logic [15:0] retired;

  logic        use_model;
  logic [15:0] tb_ir;
  logic        tb_az, tb_an;
  logic        m_init;
  logic [15:0] m_acc, m_mbr, m_ir;
  logic [11:0] m_pc, m_mar;
  logic [15:0] m_mem [0:4095];

  int n_err = 0;
  int n_chk = 0;
  int cnt  [9] = '{default: 0};
  int base [9];

  always #5 clock = ~clock;

  assign ir_in    = use_model ? m_ir : tb_ir;
  assign acc_zero = use_model ? (m_acc == 16'h0) : tb_az;
  assign acc_neg  = use_model ? m_acc[15] : tb_an;

  instr_sequencer #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .run(run),
    .step_mode(step_mode), .ir_in(ir_in),
    .acc_zero(acc_zero), .acc_neg(acc_neg),
    .mem_ready(mem_ready), .mar_write(mar_write),
    .mar_sel(mar_sel), .mbr_write(mbr_write),
    .ir_write(ir_write), .pc_inc(pc_inc),
    .pc_load(pc_load), .acc_write(acc_write),
    .acc_sel(acc_sel), .alu_op(alu_op),
    .mem_req(mem_req), .mem_we(mem_we), .busy(busy),
    .halted(halted), .illegal(illegal),
    .mem_fault(mem_fault), .retired(retired)
  );

  function automatic logic [15:0] alu(
    input logic [3:0] op, input logic [15:0] a,
    input logic [15:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b0100: return a << 1;
      4'b0101: return a >> 1;
      default: return 16'hxxxx;
    endcase
  endfunction

  // Datapath model obeying the controller's strobes
  always @(posedge clock) begin
    if (m_init) begin
      m_acc <= 16'h0;
      m_mbr <= 16'h0;
      m_ir  <= 16'h0;
      m_pc  <= 12'h0;
      m_mar <= 12'h0;
      for (int i = 0; i < 4096; i++) m_mem[i] <= 16'h0;
      m_mem[0]     <= 16'h1010;
      m_mem[1]     <= 16'h3011;
      m_mem[2]     <= 16'h2012;
      m_mem[3]     <= 16'h7000;
      m_mem[12'h10] <= 16'd5;
      m_mem[12'h11] <= 16'd7;
    end else if (use_model) begin
      if (mar_write) m_mar <= mar_sel ? ir_in[11:0] : m_pc;
      if (mbr_write) m_mbr <= m_mem[m_mar];
      if (mem_req && mem_we && mem_ready) m_mem[m_mar] <= m_acc;
      if (ir_write) m_ir <= m_mbr;
      if (pc_inc) m_pc <= m_pc + 12'd1;
      if (pc_load) m_pc <= ir_in[11:0];
      if (acc_write) begin
        case (acc_sel)
          2'd0:    m_acc <= alu(alu_op, m_acc, m_mbr);
          2'd1:    m_acc <= m_mbr;
          default: m_acc <= 16'h0;
        endcase
      end
    end
  end

  logic [1:0] last_sel;
  logic [3:0] last_alu;

  // Strobe activity counters, sampled mid-cycle
  always @(negedge clock) begin
    if (busy)      cnt[0]++;
    if (pc_inc)    cnt[1]++;
    if (pc_load)   cnt[2]++;
    if (acc_write) cnt[3]++;
    if (mem_req)   cnt[4]++;
    if (mem_req && mem_we) cnt[5]++;
    if (mbr_write) cnt[6]++;
    if (ir_write)  cnt[7]++;
    if (mar_write) cnt[8]++;
    if (acc_write) begin
      last_sel = acc_sel;
      last_alu = alu_op;
    end
  end

  function automatic logic [14:0] sv(
    input logic mw, ms, mb, iw, pi, pl, aw,
    input logic [1:0] as, input logic [3:0] ao,
    input logic mr, we);
    return {mw, ms, mb, iw, pi, pl, aw, as, ao, mr, we};
  endfunction

  function automatic logic [14:0] cur_vec();
    return {mar_write, mar_sel, mbr_write, ir_write,
            pc_inc, pc_load, acc_write, acc_sel,
            alu_op, mem_req, mem_we};
  endfunction

  function automatic int d(input int i);
    return cnt[i] - base[i];
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    run = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_pulse();
    @(posedge clock);
    #1 run = 1'b1;
    @(posedge clock);
    #1 run = 1'b0;
  endtask

  task automatic snap();
    for (int i = 0; i < 9; i++) base[i] = cnt[i];
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk({nm, " done"}, ok, 1);
    #1;
  endtask

  typedef struct {
    logic [15:0] ir;
    logic        az;
    logic        an;
    int          cyc;
    int          pci;
    int          pcl;
    int          accw;
    logic [1:0]  sel;
    logic [3:0]  alu;
    int          mreq;
    int          mwe;
    logic        hlt;
    logic        ill;
    int          ret;
  } vec_t;

  vec_t tv [21];
  logic [14:0] exp_seq [24];

  localparam logic [14:0] Z = 15'h0;

  initial begin
    logic [14:0] fa, fm, fi, ea, emr, emw, ald, aad;
    reset_n   = 1'b1;
    run       = 1'b0;
    step_mode = 1'b1;
    mem_ready = 1'b1;
    use_model = 1'b0;
    tb_ir     = 16'h0;
    tb_az     = 1'b0;
    tb_an     = 1'b0;
    m_init    = 1'b1;
    last_sel  = 2'd0;
    last_alu  = 4'd0;

    //          ir    az an cyc pci pcl aw sel alu mrq mwe h i r
    tv[0]  = '{16'h1010, 0, 0, 7, 1, 0, 1, 2'd1, 4'h0, 2, 0, 0, 0, 1};
    tv[1]  = '{16'h2012, 0, 0, 6, 1, 0, 0, 2'd0, 4'h0, 2, 1, 0, 0, 1};
    tv[2]  = '{16'h3011, 0, 0, 7, 1, 0, 1, 2'd0, 4'h0, 2, 0, 0, 0, 1};
    tv[3]  = '{16'h4011, 0, 0, 7, 1, 0, 1, 2'd0, 4'h1, 2, 0, 0, 0, 1};
    tv[4]  = '{16'h5011, 0, 0, 7, 1, 0, 1, 2'd0, 4'h8, 2, 0, 0, 0, 1};
    tv[5]  = '{16'h6011, 0, 0, 7, 1, 0, 1, 2'd0, 4'h9, 2, 0, 0, 0, 1};
    tv[6]  = '{16'h9123, 0, 0, 4, 1, 1, 0, 2'd0, 4'h0, 1, 0, 0, 0, 1};
    tv[7]  = '{16'h8400, 1, 0, 4, 2, 0, 0, 2'd0, 4'h0, 1, 0, 0, 0, 1};
    tv[8]  = '{16'h8400, 0, 0, 4, 1, 0, 0, 2'd0, 4'h0, 1, 0, 0, 0, 1};
    tv[9]  = '{16'h8C00, 1, 1, 4, 1, 0, 0, 2'd0, 4'h0, 1, 0, 0, 0, 1};
    tv[10] = '{16'h8000, 0, 1, 4, 2, 0, 0, 2'd0, 4'h0, 1, 0, 0, 0, 1};
    tv[11] = '{16'h8000, 0, 0, 4, 1, 0, 0, 2'd0, 4'h0, 1, 0, 0, 0, 1};
    tv[12] = '{16'h8800, 0, 0, 4, 2, 0, 0, 2'd0, 4'h0, 1, 0, 0, 0, 1};
    tv[13] = '{16'h8800, 1, 0, 4, 1, 0, 0, 2'd0, 4'h0, 1, 0, 0, 0, 1};
    tv[14] = '{16'hA000, 0, 0, 4, 1, 0, 1, 2'd2, 4'h0, 1, 0, 0, 0, 1};
    tv[15] = '{16'hB000, 0, 0, 4, 1, 0, 1, 2'd0, 4'h4, 1, 0, 0, 0, 1};
    tv[16] = '{16'hC000, 0, 0, 4, 1, 0, 1, 2'd0, 4'h5, 1, 0, 0, 0, 1};
    tv[17] = '{16'h7000, 0, 0, 4, 1, 0, 0, 2'd0, 4'h0, 1, 0, 1, 0, 1};
    tv[18] = '{16'h0000, 0, 0, 4, 1, 0, 0, 2'd0, 4'h0, 1, 0, 1, 1, 0};
    tv[19] = '{16'hD000, 0, 0, 4, 1, 0, 0, 2'd0, 4'h0, 1, 0, 1, 1, 0};
    tv[20] = '{16'hF000, 0, 0, 4, 1, 0, 0, 2'd0, 4'h0, 1, 0, 1, 1, 0};

    fa  = sv(1, 0, 0, 0, 0, 0, 0, 2'd0, 4'h0, 0, 0);
    fm  = sv(0, 0, 1, 0, 1, 0, 0, 2'd0, 4'h0, 1, 0);
    fi  = sv(0, 0, 0, 1, 0, 0, 0, 2'd0, 4'h0, 0, 0);
    ea  = sv(1, 1, 0, 0, 0, 0, 0, 2'd0, 4'h0, 0, 0);
    emr = sv(0, 0, 1, 0, 0, 0, 0, 2'd0, 4'h0, 1, 0);
    emw = sv(0, 0, 0, 0, 0, 0, 0, 2'd0, 4'h0, 1, 1);
    ald = sv(0, 0, 0, 0, 0, 0, 1, 2'd1, 4'h0, 0, 0);
    aad = sv(0, 0, 0, 0, 0, 0, 1, 2'd0, 4'h0, 0, 0);
    exp_seq = '{fa, fm, fi, Z, ea, emr, ald,
                fa, fm, fi, Z, ea, emr, aad,
                fa, fm, fi, Z, ea, emw,
                fa, fm, fi, Z};

    // Reset state
    do_reset();
    @(negedge clock);
    chk("rst busy", busy, 0);
    chk("rst halted", halted, 0);
    chk("rst illegal", illegal, 0);
    chk("rst mem_fault", mem_fault, 0);
    chk("rst retired", retired, 0);
    chk("rst strobes", cur_vec(), 0);

    // Single-instruction vectors in step mode
    for (int i = 0; i < 21; i++) begin
      do_reset();
      step_mode = 1'b1;
      mem_ready = 1'b1;
      tb_ir     = tv[i].ir;
      tb_az     = tv[i].az;
      tb_an     = tv[i].an;
      snap();
      run_pulse();
      wait_idle($sformatf("v%0d", i), 40);
      chk($sformatf("v%0d cycles", i), d(0), tv[i].cyc);
      chk($sformatf("v%0d pc_inc", i), d(1), tv[i].pci);
      chk($sformatf("v%0d pc_load", i), d(2), tv[i].pcl);
      chk($sformatf("v%0d acc_write", i), d(3), tv[i].accw);
      if (tv[i].accw > 0) begin
        chk($sformatf("v%0d acc_sel", i), last_sel, tv[i].sel);
        chk($sformatf("v%0d alu_op", i), last_alu, tv[i].alu);
      end
      chk($sformatf("v%0d mem_req", i), d(4), tv[i].mreq);
      chk($sformatf("v%0d mem_we", i), d(5), tv[i].mwe);
      chk($sformatf("v%0d halted", i), halted, tv[i].hlt);
      chk($sformatf("v%0d illegal", i), illegal, tv[i].ill);
      chk($sformatf("v%0d retired", i), retired, tv[i].ret);
    end

    // Full program with datapath model, free-running
    do_reset();
    use_model = 1'b1;
    step_mode = 1'b0;
    mem_ready = 1'b1;
    @(posedge clock);
    #1 m_init = 1'b0;
    run = 1'b1;
    @(posedge clock);
    #1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clock);
      chk($sformatf("prog cyc%0d", k), cur_vec(), exp_seq[k]);
    end
    @(negedge clock);
    chk("prog halted", halted, 1);
    chk("prog busy", busy, 0);
    chk("prog retired", retired, 4);
    chk("prog mem12", m_mem[12'h12], 16'd12);
    chk("prog acc", m_acc, 16'd12);
    chk("prog pc", m_pc, 12'd4);
    chk("prog halt strobes", cur_vec(), 0);
    run = 1'b0;
    use_model = 1'b0;

    // Fetch waits three cycles, then completes
    do_reset();
    step_mode = 1'b1;
    tb_ir     = 16'hA000;
    mem_ready = 1'b0;
    snap();
    run_pulse();
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1 mem_ready = 1'b1;
    wait_idle("wait", 40);
    chk("wait mem_req", d(4), 4);
    chk("wait mbr_write", d(6), 1);
    chk("wait pc_inc", d(1), 1);
    chk("wait cycles", d(0), 7);
    chk("wait mem_fault", mem_fault, 0);
    chk("wait retired", retired, 1);

    // Memory never ready: timeout fault
    do_reset();
    tb_ir     = 16'hA000;
    mem_ready = 1'b0;
    snap();
    run_pulse();
    wait_idle("tmo", 60);
    chk("tmo mem_req", d(4), 16);
    chk("tmo cycles", d(0), 18);
    chk("tmo mbr_write", d(6), 0);
    chk("tmo pc_inc", d(1), 0);
    chk("tmo mem_fault", mem_fault, 1);
    chk("tmo halted", halted, 1);
    chk("tmo retired", retired, 0);
    @(negedge clock);
    chk("tmo strobes", cur_vec(), 0);

    // Illegal opcode, run ignored in HALT, reset clears
    do_reset();
    mem_ready = 1'b1;
    tb_ir     = 16'hE000;
    run_pulse();
    wait_idle("ill", 40);
    chk("ill illegal", illegal, 1);
    chk("ill halted", halted, 1);
    chk("ill retired", retired, 0);
    snap();
    run_pulse();
    run_pulse();
    repeat (3) @(negedge clock);
    chk("ill run busy", d(0), 0);
    chk("ill run strobes",
        d(1) + d(2) + d(3) + d(4) + d(6) + d(7) + d(8), 0);
    #1 reset_n = 1'b0;
    #1;
    chk("ill rst illegal", illegal, 0);
    chk("ill rst halted", halted, 0);
    chk("ill rst busy", busy, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Asynchronous reset while stalled in EXEC_MEM
    do_reset();
    step_mode = 1'b1;
    mem_ready = 1'b1;
    tb_ir     = 16'h1010;
    run_pulse();
    repeat (4) @(posedge clock);
    #1 mem_ready = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("em pre mem_req", mem_req, 1);
    chk("em pre busy", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("em rst strobes", cur_vec(), 0);
    chk("em rst busy", busy, 0);
    chk("em rst retired", retired, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
